// File: rtl/verificador_senha.sv
// Digit-serial password checker: assembles DIGITS digits MSD-first, compares against senha,
// pulses match/mismatch, and locks out for LOCK_CYCLES cycles after MAX_TRIES consecutive failures.
module verificador_senha #(
   parameter int DIGIT_W     = 4,
   parameter int DIGITS      = 4,
   parameter int MAX_TRIES   = 3,
   parameter int LOCK_CYCLES = 16
) (
   input  logic                             clock,
   input  logic                             reset_n,
   input  logic                             digit_valid,
   input  logic [DIGIT_W-1:0]               digit,
   input  logic                             clear,
   input  logic [DIGITS*DIGIT_W-1:0]        senha,
   output logic                             match,
   output logic                             mismatch,
   output logic                             locked,
   output logic [$clog2(DIGITS+1)-1:0]      ndig,
   output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left
);

   localparam int CODE_W = DIGITS * DIGIT_W;
   localparam int NDIG_W = $clog2(DIGITS + 1);
   localparam int TRY_W  = $clog2(MAX_TRIES + 1);
   localparam int CNT_W  = $clog2(LOCK_CYCLES);

   localparam logic [1:0] ST_ENTRY  = 2'd0;
   localparam logic [1:0] ST_CHECK  = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   localparam logic [NDIG_W-1:0] LAST_DIG  = NDIG_W'(DIGITS - 1);
   localparam logic [TRY_W-1:0]  TRIES_MAX = TRY_W'(MAX_TRIES);
   localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(LOCK_CYCLES - 1);

   logic [1:0]        state_q, state_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic [NDIG_W-1:0] ndig_q, ndig_d;
   logic [TRY_W-1:0]  tries_q, tries_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              match_q, match_d;
   logic              mismatch_q, mismatch_d;
   logic              locked_q, locked_d;

   always_comb begin
      state_d    = state_q;
      code_d     = code_q;
      ndig_d     = ndig_q;
      tries_d    = tries_q;
      cnt_d      = cnt_q;
      match_d    = 1'b0;
      mismatch_d = 1'b0;
      locked_d   = locked_q;
      case (state_q)
         ST_ENTRY: begin
            // clear has priority: a digit arriving with it is dropped
            if (clear) begin
               ndig_d = '0;
               code_d = '0;
            end else if (digit_valid) begin
               code_d = (code_q << DIGIT_W) | CODE_W'(digit);
               ndig_d = ndig_q + NDIG_W'(1);
               if (ndig_q == LAST_DIG) state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            ndig_d = '0;
            code_d = '0;
            if (code_q == senha) begin
               match_d = 1'b1;
               tries_d = TRIES_MAX;
               state_d = ST_ENTRY;
            end else begin
               mismatch_d = 1'b1;
               // last allowed failure: saturate at zero and enter lockout
               if (tries_q <= TRY_W'(1)) begin
                  tries_d  = '0;
                  state_d  = ST_LOCKED;
                  locked_d = 1'b1;
                  cnt_d    = CNT_LOAD;
               end else begin
                  tries_d = tries_q - TRY_W'(1);
                  state_d = ST_ENTRY;
               end
            end
         end
         ST_LOCKED: begin
            ndig_d = '0;
            if (cnt_q == '0) begin
               state_d  = ST_ENTRY;
               locked_d = 1'b0;
               tries_d  = TRIES_MAX;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_ENTRY;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_ENTRY;
         code_q     <= '0;
         ndig_q     <= '0;
         tries_q    <= TRIES_MAX;
         cnt_q      <= '0;
         match_q    <= 1'b0;
         mismatch_q <= 1'b0;
         locked_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         code_q     <= code_d;
         ndig_q     <= ndig_d;
         tries_q    <= tries_d;
         cnt_q      <= cnt_d;
         match_q    <= match_d;
         mismatch_q <= mismatch_d;
         locked_q   <= locked_d;
      end
   end

   assign match      = match_q;
   assign mismatch   = mismatch_q;
   assign locked     = locked_q;
   assign ndig       = ndig_q;
   assign tries_left = tries_q;

endmodule

// File: tb/tb_verificador_senha.sv
// Bench for verificador_senha at default parameters: vector table plus hand-written
// sequences for clear, lockout and asynchronous reset, checked through an expected queue.
module tb_verificador_senha;

   logic        clock;
   logic        reset_n;
   logic        digit_valid;
   logic [3:0]  digit;
   logic        clear;
   logic [15:0] senha;
   logic        match;
   logic        mismatch;
   logic        locked;
   logic [2:0]  ndig;
   logic [1:0]  tries_left;

   verificador_senha dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .digit_valid (digit_valid),
      .digit       (digit),
      .clear       (clear),
      .senha       (senha),
      .match       (match),
      .mismatch    (mismatch),
      .locked      (locked),
      .ndig        (ndig),
      .tries_left  (tries_left)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      logic        dv;
      logic [3:0]  d;
      logic        clr;
      logic [15:0] pw;
      logic [7:0]  exp;
   } vec_t;

   vec_t       vecs[$];
   logic [7:0] exp_q[$];
   string      name_q[$];
   int         checks   = 0;
   int         failures = 0;

   // expected outputs packed as {ndig, match, mismatch, locked, tries_left}
   function automatic logic [7:0] pk(input logic [2:0] n, input logic m, input logic mm,
                                     input logic lk, input logic [1:0] t);
      return {n, m, mm, lk, t};
   endfunction

   function automatic void add(input logic dv, input logic [3:0] d, input logic clr,
                               input logic [15:0] pw, input logic [7:0] exp);
      vec_t v;
      v.dv = dv; v.d = d; v.clr = clr; v.pw = pw; v.exp = exp;
      vecs.push_back(v);
   endfunction

   task automatic check_out();
      logic [7:0] act;
      logic [7:0] exp;
      string      nm;
      act = {ndig, match, mismatch, locked, tries_left};
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL scoreboard_empty: got %h with no expected entry", act);
         return;
      end
      exp = exp_q.pop_front();
      nm  = name_q.pop_front();
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got ndig=%0d match=%0b mismatch=%0b locked=%0b tries_left=%0d, expected ndig=%0d match=%0b mismatch=%0b locked=%0b tries_left=%0d",
                  nm, act[7:5], act[4], act[3], act[2], act[1:0],
                  exp[7:5], exp[4], exp[3], exp[2], exp[1:0]);
      end
   endtask

   task automatic step(input logic dv, input logic [3:0] d, input logic clr,
                       input logic [15:0] pw, input logic [7:0] exp, input string nm);
      digit_valid = dv;
      digit       = d;
      clear       = clr;
      senha       = pw;
      exp_q.push_back(exp);
      name_q.push_back(nm);
      @(posedge clock);
      #1;
      check_out();
   endtask

   // four digits of code, then the CHECK cycle whose outcome is checked
   task automatic enter(input logic [15:0] code, input logic [15:0] pw, input logic [1:0] tr,
                        input logic exp_m, input logic [1:0] tr_after, input logic lk_after,
                        input string nm);
      for (int i = 0; i < 4; i++)
         step(1'b1, code[15-4*i -: 4], 1'b0, pw, pk(3'(i + 1), 1'b0, 1'b0, 1'b0, tr), nm);
      step(1'b0, 4'h0, 1'b0, pw, pk(3'd0, exp_m, ~exp_m, lk_after, tr_after), nm);
   endtask

   // reset lands mid-cycle; outputs must clear before any clock edge
   task automatic apply_reset(input string nm);
      digit_valid = 1'b0;
      clear       = 1'b0;
      reset_n     = 1'b0;
      #2;
      exp_q.push_back(pk(3'd0, 1'b0, 1'b0, 1'b0, 2'd3));
      name_q.push_back(nm);
      check_out();
      @(posedge clock);
      #3;
      reset_n = 1'b1;
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset_n     = 1'b1;
      digit_valid = 1'b0;
      digit       = 4'h0;
      clear       = 1'b0;
      senha       = 16'h1234;
      #1;
      apply_reset("reset_initial");

      // correct code
      add(1, 4'h1, 0, 16'h1234, pk(1, 0, 0, 0, 3));
      add(1, 4'h2, 0, 16'h1234, pk(2, 0, 0, 0, 3));
      add(1, 4'h3, 0, 16'h1234, pk(3, 0, 0, 0, 3));
      add(1, 4'h4, 0, 16'h1234, pk(4, 0, 0, 0, 3));
      add(0, 4'h0, 0, 16'h1234, pk(0, 1, 0, 0, 3));
      add(0, 4'h0, 0, 16'h1234, pk(0, 0, 0, 0, 3));
      // wrong code, with a digit offered during CHECK that must be ignored, then correct
      add(1, 4'h1, 0, 16'h1234, pk(1, 0, 0, 0, 3));
      add(1, 4'h2, 0, 16'h1234, pk(2, 0, 0, 0, 3));
      add(1, 4'h3, 0, 16'h1234, pk(3, 0, 0, 0, 3));
      add(1, 4'h5, 0, 16'h1234, pk(4, 0, 0, 0, 3));
      add(1, 4'h1, 0, 16'h1234, pk(0, 0, 1, 0, 2));
      add(1, 4'h1, 0, 16'h1234, pk(1, 0, 0, 0, 2));
      add(1, 4'h2, 0, 16'h1234, pk(2, 0, 0, 0, 2));
      add(1, 4'h3, 0, 16'h1234, pk(3, 0, 0, 0, 2));
      add(1, 4'h4, 0, 16'h1234, pk(4, 0, 0, 0, 2));
      add(0, 4'h0, 0, 16'h1234, pk(0, 1, 0, 0, 3));
      // full-width compare: top digit must participate
      add(1, 4'hD, 0, 16'hD000, pk(1, 0, 0, 0, 3));
      add(1, 4'h0, 0, 16'hD000, pk(2, 0, 0, 0, 3));
      add(1, 4'h0, 0, 16'hD000, pk(3, 0, 0, 0, 3));
      add(1, 4'h0, 0, 16'hD000, pk(4, 0, 0, 0, 3));
      add(0, 4'h0, 0, 16'hD000, pk(0, 1, 0, 0, 3));
      add(1, 4'hD, 0, 16'h2000, pk(1, 0, 0, 0, 3));
      add(1, 4'h0, 0, 16'h2000, pk(2, 0, 0, 0, 3));
      add(1, 4'h0, 0, 16'h2000, pk(3, 0, 0, 0, 3));
      add(1, 4'h0, 0, 16'h2000, pk(4, 0, 0, 0, 3));
      add(0, 4'h0, 0, 16'h2000, pk(0, 0, 1, 0, 2));
      add(0, 4'h0, 0, 16'h2000, pk(0, 0, 0, 0, 2));
      for (int i = 0; i < vecs.size(); i++)
         step(vecs[i].dv, vecs[i].d, vecs[i].clr, vecs[i].pw, vecs[i].exp, $sformatf("tbl[%0d]", i));

      apply_reset("reset_after_table");

      // clear, and clear winning over digit_valid
      step(1'b1, 4'h1, 1'b0, 16'h1234, pk(1, 0, 0, 0, 3), "clear_d1");
      step(1'b1, 4'h2, 1'b0, 16'h1234, pk(2, 0, 0, 0, 3), "clear_d2");
      step(1'b0, 4'h0, 1'b1, 16'h1234, pk(0, 0, 0, 0, 3), "clear_only");
      step(1'b1, 4'h7, 1'b1, 16'h1234, pk(0, 0, 0, 0, 3), "clear_with_digit");
      enter(16'h1234, 16'h1234, 2'd3, 1'b1, 2'd3, 1'b0, "clear_then_match");

      // lockout: 16 locked cycles, digits ignored, then recovery
      enter(16'h0000, 16'h1234, 2'd3, 1'b0, 2'd2, 1'b0, "lock_try1");
      enter(16'h0000, 16'h1234, 2'd2, 1'b0, 2'd1, 1'b0, "lock_try2");
      enter(16'h0000, 16'h1234, 2'd1, 1'b0, 2'd0, 1'b1, "lock_try3");
      for (int i = 0; i < 15; i++)
         step(1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 16'h1234,
              pk(0, 0, 0, 1, 0), "lock_hold");
      step(1'b0, 4'h0, 1'b0, 16'h1234, pk(0, 0, 0, 0, 3), "lock_release");
      enter(16'h1234, 16'h1234, 2'd3, 1'b1, 2'd3, 1'b0, "after_lock");

      // reset after two digits
      step(1'b1, 4'h1, 1'b0, 16'h1234, pk(1, 0, 0, 0, 3), "rst_entry_d1");
      step(1'b1, 4'h2, 1'b0, 16'h1234, pk(2, 0, 0, 0, 3), "rst_entry_d2");
      apply_reset("rst_mid_entry");
      enter(16'h1234, 16'h1234, 2'd3, 1'b1, 2'd3, 1'b0, "rst_entry_match");

      // reset five cycles into a lockout
      enter(16'h4321, 16'h1234, 2'd3, 1'b0, 2'd2, 1'b0, "rst_lock_try1");
      enter(16'h4321, 16'h1234, 2'd2, 1'b0, 2'd1, 1'b0, "rst_lock_try2");
      enter(16'h4321, 16'h1234, 2'd1, 1'b0, 2'd0, 1'b1, "rst_lock_try3");
      for (int i = 0; i < 4; i++)
         step(1'b0, 4'h0, 1'b0, 16'h1234, pk(0, 0, 0, 1, 0), "rst_lock_hold");
      apply_reset("rst_mid_lock");
      enter(16'h1234, 16'h1234, 2'd3, 1'b1, 2'd3, 1'b0, "rst_lock_match");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
